assoc_cache: RTL and testbench

ASSOC_CACHE -- requirements
Module: assoc_cache

---
 rtl/assoc_cache_pkg.sv | 28 ++
 rtl/assoc_cache_if.sv | 36 +++
 rtl/assoc_cache_plru.sv | 52 +++++
 rtl/assoc_cache.sv | 188 ++++++++++++++++++
 tb/tb_assoc_cache.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/assoc_cache_pkg.sv
// Shared types for the set-associative LC-3b cache: line/word types, controller
// states and the byte-enable merge used on write hits.
package lc3b_types;

  typedef logic [127:0] lc3b_c_line;
  typedef logic [15:0]  lc3b_word;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2
  } cache_state_t;

  localparam int OFFSET_W       = 3;
  localparam int WORDS_PER_LINE = 8;

  function automatic lc3b_c_line merge_word(input lc3b_c_line line,
                                            input logic [2:0]  off,
                                            input logic [1:0]  sel,
                                            input lc3b_word    dat);
    lc3b_c_line r;
    r = line;
    if (sel[0]) r[{off, 4'b0000} +: 8] = dat[7:0];
    if (sel[1]) r[{off, 4'b1000} +: 8] = dat[15:8];
    return r;
  endfunction

endpackage

// File: rtl/assoc_cache_if.sv
// CPU-side and memory-side bus bundle of the cache; slave is the cache itself,
// master is whatever drives CPU requests and answers line transfers.
interface assoc_cache_if;
  import lc3b_types::*;

  logic       cpu_stb;
  logic       cpu_we;
  logic [1:0] cpu_sel;
  logic [15:0] cpu_adr;
  lc3b_word   cpu_dat_m;
  lc3b_word   cpu_dat_s;
  logic       cpu_ack;

  logic       mem_cyc;
  logic       mem_stb;
  logic       mem_we;
  logic [15:0] mem_adr;
  lc3b_c_line mem_dat_m;
  lc3b_c_line mem_dat_s;
  logic       mem_ack;

  modport slave (
    input  cpu_stb, cpu_we, cpu_sel, cpu_adr, cpu_dat_m,
    output cpu_dat_s, cpu_ack,
    output mem_cyc, mem_stb, mem_we, mem_adr, mem_dat_m,
    input  mem_dat_s, mem_ack
  );

  modport master (
    output cpu_stb, cpu_we, cpu_sel, cpu_adr, cpu_dat_m,
    input  cpu_dat_s, cpu_ack,
    input  mem_cyc, mem_stb, mem_we, mem_adr, mem_dat_m,
    output mem_dat_s, mem_ack
  );

endinterface

// File: rtl/assoc_cache_plru.sv
// Per-set tree pseudo-LRU: names the replacement way for the looked-up set and
// flips the tree to point away from a touched way.
module assoc_cache_plru
  import lc3b_types::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int NUM_SETS = 8,
  localparam int IDX_W = $clog2(NUM_SETS),
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [WAY_W-1:0] victim,
  input  logic             touch,
  input  logic [IDX_W-1:0] touch_idx,
  input  logic [WAY_W-1:0] touch_way
);

  if (NUM_WAYS == 1) begin : g_none
    assign victim = '0;
  end else begin : g_tree
    logic [NUM_WAYS-2:0] bits_q [NUM_SETS];
    logic [NUM_WAYS-2:0] rd_bits;
    logic [NUM_WAYS-2:0] upd_bits;

    assign rd_bits = bits_q[rd_idx];

    if (NUM_WAYS == 2) begin : g_two
      assign victim   = rd_bits[0];
      assign upd_bits = ~touch_way[0];
    end else begin : g_four
      // bit0 picks the half, bit1/bit2 pick the way inside the left/right half
      assign victim = rd_bits[0] ? {1'b1, rd_bits[2]} : {1'b0, rd_bits[1]};
      always_comb begin
        upd_bits    = bits_q[touch_idx];
        upd_bits[0] = ~touch_way[1];
        if (touch_way[1]) upd_bits[2] = ~touch_way[0];
        else              upd_bits[1] = ~touch_way[0];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < NUM_SETS; s++) bits_q[s] <= '0;
      end else if (touch) begin
        bits_q[touch_idx] <= upd_bits;
      end
    end
  end

endmodule

// File: rtl/assoc_cache.sv
// Write-back, write-allocate set-associative cache between an LC-3b CPU word bus
// and a 128-bit line memory bus. Hits complete in the request cycle.
//
// state     | meaning
// IDLE      | look up request; hit acks at once, miss picks a victim
// WRITEBACK | dirty victim line is being written to memory
// FILL      | requested line is being read from memory
module assoc_cache
  import lc3b_types::*;
#(
  parameter int NUM_WAYS = 2,
  parameter int NUM_SETS = 8
) (
  input logic          clk,
  input logic          rst_n,
  assoc_cache_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 16 - OFFSET_W - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  cache_state_t state_q, state_d;

  lc3b_c_line          data_arr [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]    tag_arr  [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0] valid_q  [NUM_SETS];
  logic [NUM_WAYS-1:0] dirty_q  [NUM_SETS];

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       off;

  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             inv_found;
  logic [WAY_W-1:0] inv_way;
  logic [WAY_W-1:0] plru_victim;
  logic [WAY_W-1:0] victim;
  lc3b_c_line       hit_line;

  logic [12:0]      line_q;
  logic [WAY_W-1:0] vic_q;
  logic [IDX_W-1:0] line_idx;
  logic [TAG_W-1:0] line_tag;

  logic ack;
  logic miss_start;
  logic wb_done;
  logic fill_done;
  logic wr_hit;

  assign idx      = bus.cpu_adr[OFFSET_W +: IDX_W];
  assign tag      = bus.cpu_adr[OFFSET_W + IDX_W +: TAG_W];
  assign off      = bus.cpu_adr[2:0];
  assign line_idx = line_q[IDX_W-1:0];
  assign line_tag = line_q[IDX_W +: TAG_W];

  // Descending scan so the lowest-numbered matching/invalid way wins.
  always_comb begin
    logic [WAY_W-1:0] wi;
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    wi        = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      wi = WAY_W'(w);
      if (valid_q[idx][wi] && (tag_arr[idx][wi] == tag)) begin
        hit     = 1'b1;
        hit_way = wi;
      end
      if (!valid_q[idx][wi]) begin
        inv_found = 1'b1;
        inv_way   = wi;
      end
    end
  end

  assign victim        = inv_found ? inv_way : plru_victim;
  assign hit_line      = data_arr[idx][hit_way];
  assign bus.cpu_dat_s = hit_line[{off, 4'b0000} +: 16];
  assign bus.cpu_ack   = ack;
  assign wr_hit        = ack & bus.cpu_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ack         = 1'b0;
    miss_start  = 1'b0;
    wb_done     = 1'b0;
    fill_done   = 1'b0;
    bus.mem_cyc = 1'b0;
    bus.mem_stb = 1'b0;
    bus.mem_we  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cpu_stb) begin
          if (hit) begin
            ack = 1'b1;
          end else begin
            miss_start = 1'b1;
            state_d    = dirty_q[idx][victim] ? WRITEBACK : FILL;
          end
        end
      end
      WRITEBACK: begin
        bus.mem_cyc = 1'b1;
        bus.mem_stb = 1'b1;
        bus.mem_we  = 1'b1;
        if (bus.mem_ack) begin
          wb_done = 1'b1;
          // An abandoned request needs no fill once the victim is safe.
          state_d = bus.cpu_stb ? FILL : IDLE;
        end
      end
      FILL: begin
        bus.mem_cyc = 1'b1;
        bus.mem_stb = 1'b1;
        if (bus.mem_ack) begin
          fill_done = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Miss context is frozen so the memory bus stays stable for the whole transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
      vic_q  <= '0;
    end else if (miss_start) begin
      line_q <= bus.cpu_adr[15:3];
      vic_q  <= victim;
    end
  end

  always_comb begin
    if (state_q == WRITEBACK) bus.mem_adr = {tag_arr[line_idx][vic_q], line_idx, 3'b000};
    else                      bus.mem_adr = {line_q, 3'b000};
  end
  assign bus.mem_dat_m = data_arr[line_idx][vic_q];

  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_arr[line_idx][vic_q] <= bus.mem_dat_s;
      tag_arr[line_idx][vic_q]  <= line_tag;
    end else if (wr_hit) begin
      data_arr[idx][hit_way] <= merge_word(hit_line, off, bus.cpu_sel, bus.cpu_dat_m);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
      end
    end else begin
      if (fill_done) begin
        valid_q[line_idx][vic_q] <= 1'b1;
        dirty_q[line_idx][vic_q] <= 1'b0;
      end
      if (wb_done) dirty_q[line_idx][vic_q] <= 1'b0;
      if (wr_hit && (bus.cpu_sel != 2'b00)) dirty_q[idx][hit_way] <= 1'b1;
    end
  end

  assoc_cache_plru #(
    .NUM_WAYS(NUM_WAYS),
    .NUM_SETS(NUM_SETS)
  ) u_plru (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_idx   (idx),
    .victim   (plru_victim),
    .touch    (ack | fill_done),
    .touch_idx(fill_done ? line_idx : idx),
    .touch_way(fill_done ? vic_q : hit_way)
  );

endmodule

// File: tb/tb_assoc_cache.sv
// Directed bench for assoc_cache (2 ways, 8 sets) against a recency-list cache
// model with a per-cycle compare process and literal spot checks.
module tb_assoc_cache;

  localparam int NW = 2;
  localparam int NS = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  assoc_cache_if bus ();

  assoc_cache #(
    .NUM_WAYS(NW),
    .NUM_SETS(NS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  bit           chk_en      = 1'b0;
  bit           exp_ack     = 1'b0;
  bit           exp_rd      = 1'b0;
  logic [15:0]  exp_dat     = '0;
  int           exp_mem     = 0;    // 0 none, 1 write-back, 2 fill
  logic [15:0]  exp_mem_adr = '0;
  logic [127:0] exp_wb_line = '0;

  logic [15:0] cap_dat;
  logic [15:0] last_wb_adr   = '0;
  logic [15:0] last_fill_adr = '0;
  int          wb_cnt   = 0;
  int          fill_cnt = 0;

  // Cache model: resident lines per set in recency order (front = least recent).
  int           res_q [NS][$];
  logic [127:0] cdata [int];
  bit           cdirty [int];
  logic [127:0] mem_img [int];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] mem_line(input int line);
    logic [127:0] l;
    if (mem_img.exists(line)) return mem_img[line];
    for (int k = 0; k < 8; k++) l[k*16 +: 16] = 16'h1000 + 16'((line - 8) * 256) + 16'(k);
    return l;
  endfunction

  function automatic bit in_set(input int set, input int line);
    foreach (res_q[set][i]) if (res_q[set][i] == line) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void drop_line(input int set, input int line);
    int pos = -1;
    foreach (res_q[set][i]) if (res_q[set][i] == line) pos = i;
    if (pos >= 0) res_q[set].delete(pos);
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("cpu_ack", bus.cpu_ack, exp_ack);
      if (exp_ack && exp_rd) check("cpu_dat_s", bus.cpu_dat_s, exp_dat);
      check("mem_stb", bus.mem_stb, exp_mem != 0);
      check("mem_cyc", bus.mem_cyc, exp_mem != 0);
      if (exp_mem != 0) begin
        check("mem_we", bus.mem_we, exp_mem == 1);
        check("mem_adr", bus.mem_adr, exp_mem_adr);
        if (exp_mem == 1) check("mem_dat_m", bus.mem_dat_m, exp_wb_line);
      end
    end
    if (bus.cpu_ack) cap_dat = bus.cpu_dat_s;
    if (bus.mem_stb && bus.mem_ack) begin
      if (bus.mem_we) begin wb_cnt++;   last_wb_adr   = bus.mem_adr; end
      else            begin fill_cnt++; last_fill_adr = bus.mem_adr; end
    end
  end

  // Called just after a rising edge; returns the word seen on the ack cycle.
  task automatic req(input bit we, input logic [15:0] adr, input logic [1:0] sel,
                     input logic [15:0] dat, input int lat, input bit drop,
                     output logic [15:0] rdat);
    int line, set, vic;
    bit wb;
    logic [127:0] l;
    line = int'(adr[15:3]);
    set  = line % NS;
    vic  = -1;
    wb   = 1'b0;
    rdat = 'x;
    bus.cpu_stb = 1'b1; bus.cpu_we = we; bus.cpu_sel = sel;
    bus.cpu_adr = adr;  bus.cpu_dat_m = dat;
    if (!in_set(set, line)) begin
      if (res_q[set].size() == NW) begin
        vic = res_q[set][0];
        wb  = cdirty[vic];
      end
      @(posedge clk); #1;
      if (wb) begin
        exp_mem = 1; exp_mem_adr = 16'(vic * 8); exp_wb_line = cdata[vic];
        repeat (lat) begin @(posedge clk); #1; end
        bus.mem_ack = 1'b1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        mem_img[vic] = cdata[vic];
      end
      exp_mem = 2; exp_mem_adr = {adr[15:3], 3'b000};
      bus.mem_dat_s = mem_line(line);
      if (drop) bus.cpu_stb = 1'b0;
      repeat (lat) begin @(posedge clk); #1; end
      bus.mem_ack = 1'b1;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      exp_mem = 0;
      if (vic >= 0) begin
        drop_line(set, vic);
        cdata.delete(vic);
        cdirty.delete(vic);
      end
      res_q[set].push_back(line);
      cdata[line]  = mem_line(line);
      cdirty[line] = 1'b0;
    end
    if (!drop) begin
      exp_ack = 1'b1;
      exp_rd  = !we;
      l       = cdata[line];
      exp_dat = l[int'(adr[2:0]) * 16 +: 16];
      cap_dat = 'x;
      @(posedge clk); #1;
      rdat = cap_dat;
      drop_line(set, line);
      res_q[set].push_back(line);
      if (we) begin
        if (sel[0]) l[int'(adr[2:0]) * 16 +: 8]     = dat[7:0];
        if (sel[1]) l[int'(adr[2:0]) * 16 + 8 +: 8] = dat[15:8];
        cdata[line] = l;
        if (sel != 2'b00) cdirty[line] = 1'b1;
      end
      exp_ack = 1'b0;
    end
    bus.cpu_stb = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [15:0] d;
    int wb0, fc0;
    bus.cpu_stb = 1'b0; bus.cpu_we = 1'b0; bus.cpu_sel = 2'b00;
    bus.cpu_adr = '0;   bus.cpu_dat_m = '0;
    bus.mem_dat_s = '0; bus.mem_ack = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_ack", bus.cpu_ack, 1'b0);
    check("rst_mem_cyc", bus.mem_cyc, 1'b0);
    check("rst_mem_stb", bus.mem_stb, 1'b0);
    check("rst_mem_we",  bus.mem_we,  1'b0);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // cold read, then zero-wait hit in same line
    req(1'b0, 16'h0040, 2'b00, 16'h0000, 2, 1'b0, d);
    check("cold_rd_0040", d, 16'h1000);
    check("cold_fill_adr", last_fill_adr, 16'h0040);
    req(1'b0, 16'h0043, 2'b00, 16'h0000, 2, 1'b0, d);
    check("hit_rd_0043", d, 16'h1003);
    check("fills_after_hit", fill_cnt, 1);

    // low-byte write hit then read back
    req(1'b1, 16'h0041, 2'b01, 16'hABCD, 2, 1'b0, d);
    req(1'b0, 16'h0041, 2'b00, 16'h0000, 2, 1'b0, d);
    check("merge_rd_0041", d, 16'h10CD);

    // dirty victim write-back in set 0
    req(1'b0, 16'h0080, 2'b00, 16'h0000, 1, 1'b0, d);
    check("fill_rd_0080", d, 16'h1800);
    req(1'b1, 16'h0080, 2'b11, 16'h5A5A, 1, 1'b0, d);
    req(1'b0, 16'h0040, 2'b00, 16'h0000, 1, 1'b0, d);
    req(1'b0, 16'h00C0, 2'b00, 16'h0000, 3, 1'b0, d);
    check("rd_00c0", d, 16'h2000);
    check("wb_adr", last_wb_adr, 16'h0080);
    check("wb_count", wb_cnt, 1);
    fc0 = fill_cnt;
    req(1'b0, 16'h0041, 2'b00, 16'h0000, 1, 1'b0, d);
    check("still_hit_0041", d, 16'h10CD);
    check("no_fill_on_hit", fill_cnt, fc0);

    // clean victim: fill only; returns the written-back data
    req(1'b0, 16'h0080, 2'b00, 16'h0000, 0, 1'b0, d);
    check("wb_data_0080", d, 16'h5A5A);
    check("clean_victim_no_wb", wb_cnt, 1);

    // zero byte-enable write must not dirty the line
    req(1'b0, 16'h0050, 2'b00, 16'h0000, 1, 1'b0, d);
    req(1'b1, 16'h0050, 2'b00, 16'hFFFF, 1, 1'b0, d);
    req(1'b0, 16'h0090, 2'b00, 16'h0000, 1, 1'b0, d);
    req(1'b0, 16'h00D0, 2'b00, 16'h0000, 1, 1'b0, d);
    check("rd_00d0", d, 16'h2200);
    check("sel0_no_wb", wb_cnt, 1);

    // write miss allocates, high-byte merge
    req(1'b1, 16'h004A, 2'b10, 16'h7700, 2, 1'b0, d);
    req(1'b0, 16'h004A, 2'b00, 16'h0000, 2, 1'b0, d);
    check("write_miss_rd", d, 16'h7702);

    // stray mem_ack in IDLE is ignored
    fc0 = fill_cnt;
    bus.mem_dat_s = {8{16'hDEAD}};
    bus.mem_ack   = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack   = 1'b0;
    req(1'b0, 16'h004A, 2'b00, 16'h0000, 1, 1'b0, d);
    check("idle_ack_ignored", d, 16'h7702);
    check("idle_ack_no_fill", fill_cnt, fc0);

    // request dropped during fill
    fc0 = fill_cnt;
    req(1'b0, 16'h0058, 2'b00, 16'h0000, 2, 1'b1, d);
    req(1'b0, 16'h005A, 2'b00, 16'h0000, 2, 1'b0, d);
    check("dropped_line_hit", d, 16'h1302);
    check("dropped_fill_count", fill_cnt, fc0 + 1);

    // reset in the middle of a fill
    bus.cpu_stb = 1'b1; bus.cpu_we = 1'b0; bus.cpu_sel = 2'b00; bus.cpu_adr = 16'h0068;
    @(posedge clk); #1;
    exp_mem = 2; exp_mem_adr = 16'h0068;
    @(posedge clk); #1;
    rst_n = 1'b0;
    exp_mem = 0;
    bus.cpu_stb = 1'b0;
    #1;
    check("rst_drop_mem_cyc", bus.mem_cyc, 1'b0);
    check("rst_drop_mem_stb", bus.mem_stb, 1'b0);
    for (int s = 0; s < NS; s++) res_q[s].delete();
    cdata.delete();
    cdirty.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    fc0 = fill_cnt;
    req(1'b0, 16'h0041, 2'b00, 16'h0000, 1, 1'b0, d);
    check("post_rst_rd_0041", d, 16'h1001);
    check("post_rst_miss", fill_cnt, fc0 + 1);

    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish (got running, expected done)");
    $fatal(1);
  end

endmodule
